// File: rtl/mux_n_1_stream.sv
// Registered N:1 stream concentrator: manual channel select or fair round-robin, tags source channel.
// Latency 1 cycle, one word/cycle; while out_valid && !out_ready the output holds and all in_ready drop.
module mux_n_1_stream #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 1,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic [SEL_W-1:0]  r_rr_ptr;
  logic [SEL_W-1:0]  r_out_ch;
  logic [DATA_W-1:0] r_out_dat;
  logic              r_out_vld;

  logic              w_load_en;
  logic              w_xfer;
  logic              w_gnt_vld;
  logic [SEL_W-1:0]  w_gnt;
  logic [DATA_W-1:0] w_gnt_dat;
  logic              w_hi_vld;
  logic [SEL_W-1:0]  w_hi;
  logic              w_lo_vld;
  logic [SEL_W-1:0]  w_lo;

  assign w_load_en = !r_out_vld || out_ready;

  // Cyclic scan from r_rr_ptr = lowest valid index >= ptr, else lowest valid index overall.
  always_comb begin
    w_hi_vld = 1'b0;
    w_hi     = '0;
    w_lo_vld = 1'b0;
    w_lo     = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        w_lo_vld = 1'b1;
        w_lo     = SEL_W'(i);
        if (SEL_W'(i) >= r_rr_ptr) begin
          w_hi_vld = 1'b1;
          w_hi     = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    if (mode) begin
      w_gnt_vld = w_lo_vld;
      w_gnt     = w_hi_vld ? w_hi : w_lo;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = sel;
        end
      end
    end
  end

  always_comb begin
    w_gnt_dat = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_gnt == SEL_W'(i)) w_gnt_dat = in_data[i*DATA_W +: DATA_W];
    end
  end

  assign w_xfer = w_load_en && w_gnt_vld;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = rst_n && w_xfer && (w_gnt == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_out_ch  <= '0;
      r_rr_ptr  <= '0;
    end else if (w_load_en) begin
      r_out_vld <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_out_dat <= w_gnt_dat;
        r_out_ch  <= w_gnt;
        if (mode) r_rr_ptr <= (w_gnt == SEL_W'(N_CH - 1)) ? '0 : w_gnt + SEL_W'(1);
      end
    end
  end

  assign out_data  = r_out_dat;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_vld;

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Bench for mux_n_1_stream: an 8x1 and a 10x4 instance run in lockstep against a cyclic-scan reference.
module tb_mux_n_1_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  a_in_data;
  logic [7:0]  a_in_valid;
  logic [7:0]  a_in_ready;
  logic        a_mode;
  logic [2:0]  a_sel;
  logic [0:0]  a_out_data;
  logic [2:0]  a_out_ch;
  logic        a_out_valid;
  logic        a_out_ready;

  logic [39:0] b_in_data;
  logic [9:0]  b_in_valid;
  logic [9:0]  b_in_ready;
  logic        b_mode;
  logic [3:0]  b_sel;
  logic [3:0]  b_out_data;
  logic [3:0]  b_out_ch;
  logic        b_out_valid;
  logic        b_out_ready;

  mux_n_1_stream #(.N_CH(8), .DATA_W(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .mode(a_mode), .sel(a_sel), .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  mux_n_1_stream #(.N_CH(10), .DATA_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .mode(b_mode), .sel(b_sel), .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_n [2];
  int   m_w [2];
  logic m_vld [2];
  int   m_dat [2];
  int   m_ch [2];
  int   m_ptr [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_grant(int n, logic md, int s, logic [63:0] v, int ptr);
    int j;
    if (!md) return (s < n && v[s]) ? s : -1;
    for (int k = 0; k < n; k++) begin
      j = (ptr + k) % n;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_vld[d] = 1'b0; m_dat[d] = 0; m_ch[d] = 0; m_ptr[d] = 0;
    end
  endtask

  task automatic check_outs();
    chk("a_out_valid", 64'(a_out_valid), 64'(m_vld[0]));
    chk("a_out_data",  64'(a_out_data),  64'(m_dat[0]));
    chk("a_out_ch",    64'(a_out_ch),    64'(m_ch[0]));
    chk("b_out_valid", 64'(b_out_valid), 64'(m_vld[1]));
    chk("b_out_data",  64'(b_out_data),  64'(m_dat[1]));
    chk("b_out_ch",    64'(b_out_ch),    64'(m_ch[1]));
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic tick();
    logic [63:0] v [2];
    logic [63:0] din [2];
    logic        md [2];
    logic        ordy [2];
    int          s [2];
    int          g [2];
    logic        le [2];
    logic [63:0] er;
    logic [63:0] got;
    @(negedge clk);
    v[0] = 64'(a_in_valid); v[1] = 64'(b_in_valid);
    din[0] = 64'(a_in_data); din[1] = 64'(b_in_data);
    md[0] = a_mode; md[1] = b_mode;
    s[0] = int'(a_sel); s[1] = int'(b_sel);
    ordy[0] = a_out_ready; ordy[1] = b_out_ready;
    for (int d = 0; d < 2; d++) begin
      le[d] = !m_vld[d] || ordy[d];
      g[d]  = ref_grant(m_n[d], md[d], s[d], v[d], m_ptr[d]);
      er    = (le[d] && g[d] >= 0) ? (64'd1 << g[d]) : 64'd0;
      got   = (d == 0) ? 64'(a_in_ready) : 64'(b_in_ready);
      chk((d == 0) ? "a_in_ready" : "b_in_ready", got, er);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (le[d]) begin
        if (g[d] >= 0) begin
          m_vld[d] = 1'b1;
          m_dat[d] = int'((din[d] >> (g[d] * m_w[d])) & ((64'd1 << m_w[d]) - 64'd1));
          m_ch[d]  = g[d];
          if (md[d]) m_ptr[d] = (g[d] + 1) % m_n[d];
        end else begin
          m_vld[d] = 1'b0;
        end
      end
    end
    check_outs();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    chk("a_rdy_in_reset", 64'(a_in_ready), 64'd0);
    chk("b_rdy_in_reset", 64'(b_in_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int exp_seq [6] = '{1, 2, 4, 7, 1, 2};

  initial begin
    m_n[0] = 8;  m_w[0] = 1;
    m_n[1] = 10; m_w[1] = 4;
    model_reset();
    a_in_data = 8'b0101_0101; a_in_valid = 8'hFF; a_mode = 1'b0; a_sel = '0; a_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) b_in_data[i*4 +: 4] = 4'(i + 1);
    b_in_valid = 10'h3FF; b_mode = 1'b0; b_sel = '0; b_out_ready = 1'b1;
    #1;
    check_outs();
    chk("a_rdy_in_reset", 64'(a_in_ready), 64'd0);
    chk("b_rdy_in_reset", 64'(b_in_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Manual sweep of sel over alternating data.
    for (int i = 0; i < 8; i++) begin
      a_sel = 3'(i);
      tick();
      chk("man_sweep_dat", 64'(a_out_data), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("man_sweep_ch", 64'(a_out_ch), 64'(i));
    end

    a_mode = 1'b1; a_in_valid = 8'b1001_0110;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_seq_ch", 64'(a_out_ch), 64'(exp_seq[i]));
    end

    // Backpressure after a clean restart.
    async_reset();
    a_in_valid = 8'hFF; a_out_ready = 1'b1;
    tick();
    chk("bp_first_ch", 64'(a_out_ch), 64'd0);
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_ch", 64'(a_out_ch), 64'd0);
      chk("bp_hold_rdy", 64'(a_in_ready), 64'd0);
    end
    a_out_ready = 1'b1;
    tick();
    chk("bp_release_ch", 64'(a_out_ch), 64'd1);

    // Manual corner cases on the 10-channel instance.
    b_in_valid = 10'h3F7;
    b_sel = 4'd0; tick();
    b_sel = 4'd3; tick();
    chk("man_invalid_vld", 64'(b_out_valid), 64'd0);
    b_sel = 4'd9; tick();
    chk("man_ch9_dat", 64'(b_out_data), 64'hA);
    chk("man_ch9_ch", 64'(b_out_ch), 64'd9);
    b_sel = 4'd12;
    #1 chk("man_oob_rdy", 64'(b_in_ready), 64'd0);
    tick();

    // rr_ptr survives a manual transfer.
    b_mode = 1'b1; b_in_valid = 10'b00_0010_0000; tick();
    chk("mode_rr_ch5", 64'(b_out_ch), 64'd5);
    b_mode = 1'b0; b_sel = 4'd2; b_in_valid = 10'h3FF; tick();
    chk("mode_man_ch2", 64'(b_out_ch), 64'd2);
    b_mode = 1'b1; tick();
    chk("mode_rr_resume", 64'(b_out_ch), 64'd6);

    chk("pre_reset_vld", 64'(b_out_valid), 64'd1);
    async_reset();
    a_mode = 1'b1; a_in_valid = 8'hFF; a_out_ready = 1'b1;
    tick();
    chk("post_reset_a_ch", 64'(a_out_ch), 64'd0);
    chk("post_reset_b_ch", 64'(b_out_ch), 64'd0);

    for (int c = 0; c < 400; c++) begin
      a_in_data   = 8'($urandom);
      a_in_valid  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      a_sel       = 3'($urandom_range(0, 7));
      a_out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) a_mode = ~a_mode;
      b_in_data   = {8'($urandom), 32'($urandom)};
      b_in_valid  = ($urandom_range(0, 3) == 0) ? 10'h000 : 10'($urandom);
      b_sel       = 4'($urandom_range(0, 15));
      b_out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) b_mode = ~b_mode;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
